// File: rtl/mips32_pkg.sv
// mips32_pkg: shared types for the MIPS32 memory arbiter.
//   req_id_e     - requester identity, also used as the read-owner tag
//   lock_state_e - host lock FSM states
package mips32_pkg;

    typedef enum logic [1:0] {
        REQ_F    = 2'd0,
        REQ_D    = 2'd1,
        REQ_H    = 2'd2,
        REQ_NONE = 2'd3
    } req_id_e;

    typedef enum logic [1:0] {
        LK_NORMAL = 2'd0,
        LK_PEND   = 2'd1,
        LK_LOCKED = 2'd2
    } lock_state_e;

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// mips32_mem_arbiter_if: requester and RAM signals of the memory arbiter.
//   Fetch   : f_req, f_addr -> f_gnt, f_rvalid
//   Data    : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid
//   Host    : h_req, h_we, h_addr, h_wdata, h_lock -> h_gnt, h_rvalid
//   Shared  : rdata, core_stall
//   RAM     : mem_en, mem_we, mem_addr, mem_wdata -> RAM, mem_rdata <- RAM
//   slave  modport: the arbiter; master modport: requesters plus RAM model.
interface mips32_mem_arbiter_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
);
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_rvalid;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;

    logic          h_req;
    logic          h_we;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic          h_lock;
    logic          h_gnt;
    logic          h_rvalid;

    logic [DW-1:0] rdata;
    logic          core_stall;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  f_req, f_addr,
        output f_gnt, f_rvalid,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid,
        input  h_req, h_we, h_addr, h_wdata, h_lock,
        output h_gnt, h_rvalid,
        output rdata, core_stall,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output f_req, f_addr,
        input  f_gnt, f_rvalid,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid,
        output h_req, h_we, h_addr, h_wdata, h_lock,
        input  h_gnt, h_rvalid,
        input  rdata, core_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mips32_arb_starve.sv
// mips32_arb_starve: fetch anti-starvation counter.
//   clk1, rst  - clock, async active-high reset
//   en_i       - count/clear only while the lock FSM is NORMAL, else hold
//   f_req_i    - fetch request
//   f_gnt_i    - fetch grant this cycle
//   force_o    - fetch has waited STARVE_LIMIT cycles and must win now
module mips32_arb_starve #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk1,
    input  logic rst,
    input  logic en_i,
    input  logic f_req_i,
    input  logic f_gnt_i,
    output logic force_o
);
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (!f_req_i || f_gnt_i) begin
                cnt_d = '0;
            end else if (cnt_q != LIMIT) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Depends only on the registered count, so no loop through f_gnt.
    assign force_o = f_req_i && (cnt_q == LIMIT);
endmodule

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: shares one synchronous single-port RAM between
// fetch (F), load/store (D) and host (H).  Priority D > F > H with a
// starvation override for F; a host lock FSM gives H exclusive access and
// stalls the core.
//   clk1 - clock, all state on posedge
//   rst  - asynchronous active-high reset
//   bus  - requester handshakes, shared rdata/core_stall, RAM port
module mips32_mem_arbiter
    import mips32_pkg::*;
#(
    parameter int unsigned AW           = 10,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk1,
    input  logic                 rst,
    mips32_mem_arbiter_if.slave  bus
);
    lock_state_e   state_q, state_d;
    req_id_e       winner;
    req_id_e       rd_owner_q, rd_owner_d;
    logic          core_stall_q;
    logic          f_force;
    logic          we_mux;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;

    mips32_arb_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk1    (clk1),
        .rst     (rst),
        .en_i    (state_q == LK_NORMAL),
        .f_req_i (bus.f_req),
        .f_gnt_i (bus.f_gnt),
        .force_o (f_force)
    );

    // Winner selection; nothing is granted while reset is asserted.
    always_comb begin
        winner = REQ_NONE;
        if (!rst) begin
            unique case (state_q)
                LK_NORMAL: begin
                    if (f_force)          winner = REQ_F;
                    else if (bus.d_req)   winner = REQ_D;
                    else if (bus.f_req)   winner = REQ_F;
                    else if (bus.h_req)   winner = REQ_H;
                end
                LK_LOCKED: begin
                    if (bus.h_req)        winner = REQ_H;
                end
                default: winner = REQ_NONE;
            endcase
        end
    end

    always_comb begin
        we_mux    = 1'b0;
        addr_mux  = '0;
        wdata_mux = '0;
        unique case (winner)
            REQ_F: addr_mux = bus.f_addr;
            REQ_D: begin
                we_mux    = bus.d_we;
                addr_mux  = bus.d_addr;
                wdata_mux = bus.d_wdata;
            end
            REQ_H: begin
                we_mux    = bus.h_we;
                addr_mux  = bus.h_addr;
                wdata_mux = bus.h_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_owner_d = (winner != REQ_NONE && !we_mux) ? winner : REQ_NONE;
        state_d    = state_q;
        unique case (state_q)
            LK_NORMAL: if (bus.h_lock) state_d = LK_PEND;
            // rd_owner_d is the tag that will be in flight after this cycle;
            // the read being returned now completes in this cycle.
            LK_PEND: begin
                if (!bus.h_lock)                 state_d = LK_NORMAL;
                else if (rd_owner_d == REQ_NONE) state_d = LK_LOCKED;
            end
            LK_LOCKED: if (!bus.h_lock) state_d = LK_NORMAL;
            default: state_d = LK_NORMAL;
        endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q      <= LK_NORMAL;
            rd_owner_q   <= REQ_NONE;
            core_stall_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_owner_q   <= rd_owner_d;
            core_stall_q <= (state_d != LK_NORMAL);
        end
    end

    assign bus.f_gnt      = (winner == REQ_F);
    assign bus.d_gnt      = (winner == REQ_D);
    assign bus.h_gnt      = (winner == REQ_H);
    assign bus.f_rvalid   = (rd_owner_q == REQ_F);
    assign bus.d_rvalid   = (rd_owner_q == REQ_D);
    assign bus.h_rvalid   = (rd_owner_q == REQ_H);
    assign bus.rdata      = bus.mem_rdata;
    assign bus.core_stall = core_stall_q;
    assign bus.mem_en     = (winner != REQ_NONE);
    assign bus.mem_we     = we_mux;
    assign bus.mem_addr   = addr_mux;
    assign bus.mem_wdata  = wdata_mux;
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Bench for mips32_mem_arbiter: directed scenarios followed by random
// traffic, checked against a rule-level arbitration model and a reference
// memory through a read-response scoreboard.
module tb_mips32_mem_arbiter;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mips32_mem_arbiter #(
        .AW(AW),
        .DW(DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    // Environment RAM: synchronous, one-cycle read latency.
    logic [DW-1:0] ram     [0:1023];
    logic [DW-1:0] ref_mem [0:1023];
    always @(posedge clk1) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    typedef struct {
        int          owner;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t expq[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Grants as seen during the cycle that just ended: {f, d, h}.
    logic [2:0] gl = '0;
    always @(negedge clk1) gl <= {bus.f_gnt, bus.d_gnt, bus.h_gnt};

    // Reference model: 0 NORMAL, 1 lock pending, 2 locked.
    int m_state  = 0;
    int m_starve = 0;

    always @(negedge clk1) begin : model
        int            win;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        if (rst) begin
            check("rst_grants", {bus.f_gnt, bus.d_gnt, bus.h_gnt, bus.mem_en}, 0);
            check("rst_outputs", {bus.core_stall, bus.f_rvalid, bus.d_rvalid, bus.h_rvalid}, 0);
            m_state  = 0;
            m_starve = 0;
        end else begin
            win = -1;
            if (m_state == 0) begin
                if (bus.f_req && m_starve == LIMIT) win = 0;
                else if (bus.d_req)                 win = 1;
                else if (bus.f_req)                 win = 0;
                else if (bus.h_req)                 win = 2;
            end else if (m_state == 2 && bus.h_req) begin
                win = 2;
            end
            check("grant", {bus.f_gnt, bus.d_gnt, bus.h_gnt}, {win == 0, win == 1, win == 2});
            check("core_stall", bus.core_stall, m_state != 0);
            check("mem_en", bus.mem_en, win >= 0);
            if (win >= 0) begin
                we = 1'b0; addr = bus.f_addr; wd = '0;
                if (win == 1) begin we = bus.d_we; addr = bus.d_addr; wd = bus.d_wdata; end
                if (win == 2) begin we = bus.h_we; addr = bus.h_addr; wd = bus.h_wdata; end
                check("mem_we_addr", {bus.mem_we, bus.mem_addr}, {we, addr});
                if (we) begin
                    check("mem_wdata", bus.mem_wdata, wd);
                    ref_mem[addr] = wd;
                end else begin
                    expq.push_back('{win, ref_mem[addr], cyc});
                end
            end
            if (m_state == 0) begin
                if (bus.f_req && win != 0) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
                else                       m_starve = 0;
                if (bus.h_lock) m_state = 1;
            end else if (m_state == 1) begin
                m_state = bus.h_lock ? 2 : 0;
            end else if (!bus.h_lock) begin
                m_state = 0;
            end
        end
    end

    always @(posedge clk1) begin : monitor
        int   nrv;
        int   owner;
        exp_t e;
        #2;
        nrv = int'(bus.f_rvalid) + int'(bus.d_rvalid) + int'(bus.h_rvalid);
        if (rst) begin
            expq.delete();
            check("rst_rvalid", nrv, 0);
        end else begin
            check("rvalid_onehot", nrv <= 1, 1);
            if (nrv != 0) begin
                if (expq.size() == 0) begin
                    check("rvalid_unexpected", nrv, 0);
                end else begin
                    e     = expq.pop_front();
                    owner = bus.f_rvalid ? 0 : (bus.d_rvalid ? 1 : 2);
                    check("rd_owner", owner, e.owner);
                    check("rd_latency", cyc - 1, e.cyc);
                    check("rdata", bus.rdata, e.data);
                end
            end else if (expq.size() != 0 && expq[0].cyc < cyc) begin
                check("rvalid_missing", nrv, 1);
                void'(expq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic idle();
        bus.f_req = 1'b0; bus.f_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.h_req = 1'b0; bus.h_we = 1'b0; bus.h_addr = '0; bus.h_wdata = '0;
        bus.h_lock = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int first_f;
        int lock_left;
        for (int i = 0; i < 1024; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        idle();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step(); step();

        // D and F collide: D first, F next cycle.
        bus.d_req = 1'b1; bus.d_addr = 10'd5;
        bus.f_req = 1'b1; bus.f_addr = 10'd10;
        step();
        bus.d_req = 1'b0;
        step();
        bus.f_req = 1'b0;
        step(); step();

        // Continuous D traffic: F forced through on its 5th waiting cycle.
        first_f   = -1;
        bus.f_req = 1'b1; bus.f_addr = 10'd30;
        for (int i = 0; i < 8; i++) begin
            bus.d_req  = 1'b1;
            bus.d_addr = 10'(20 + i);
            step();
            if (gl[2]) begin
                if (first_f < 0) first_f = i;
                bus.f_req = 1'b0;
            end
        end
        check("starve_force_cycle", first_f, LIMIT);
        bus.d_req = 1'b0;
        step(); step();

        // Lock while an F read is granted, host write, unlock with host read.
        bus.f_req = 1'b1; bus.f_addr = 10'd12; bus.h_lock = 1'b1;
        step();
        bus.f_req = 1'b0;
        step();
        bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 10'd0; bus.h_wdata = 32'h2C00000A;
        step();
        check("locked_stall", bus.core_stall, 1);
        bus.h_we = 1'b0; bus.h_lock = 1'b0;
        step();
        bus.h_req = 1'b0;
        check("host_readback", {bus.h_rvalid, bus.rdata}, {1'b1, 32'h2C00000A});
        check("unlock_stall", bus.core_stall, 0);
        step(); step();

        // Store then load the same word on consecutive cycles.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'd100; bus.d_wdata = 32'hDEADBEEF;
        step();
        bus.d_we = 1'b0;
        step();
        bus.d_req = 1'b0;
        check("raw_readback", {bus.d_rvalid, bus.rdata}, {1'b1, 32'hDEADBEEF});
        step();

        // Reset lands between a D read grant and its response.
        bus.d_req = 1'b1; bus.d_addr = 10'd7;
        @(negedge clk1);
        #3;
        rst = 1'b1;
        bus.d_req = 1'b0;
        step();
        check("rst_drop_rvalid", bus.d_rvalid, 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_rvalid", bus.d_rvalid, 0);
        check("post_rst_stall", bus.core_stall, 0);

        // Random traffic with occasional host lock windows.
        lock_left = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!bus.f_req || gl[2]) begin
                bus.f_req  = ($urandom_range(0, 99) < 50);
                bus.f_addr = 10'($urandom_range(0, 15));
            end
            if (!bus.d_req || gl[1]) begin
                bus.d_req   = ($urandom_range(0, 99) < 60);
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = 10'($urandom_range(0, 15));
                bus.d_wdata = $urandom;
            end
            if (!bus.h_req || gl[0]) begin
                bus.h_req   = ($urandom_range(0, 99) < (bus.h_lock ? 70 : 15));
                bus.h_we    = 1'($urandom_range(0, 1));
                bus.h_addr  = 10'($urandom_range(0, 15));
                bus.h_wdata = $urandom;
            end
            if (bus.h_lock) begin
                lock_left--;
                if (lock_left <= 0) bus.h_lock = 1'b0;
            end else if ($urandom_range(0, 99) < 3) begin
                bus.h_lock = 1'b1;
                lock_left  = $urandom_range(1, 12);
            end
            step();
        end

        idle();
        repeat (3) step();
        check("queue_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
